// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode encodings and sequence helpers for the stride counter
//
// Purpose : mode encoding, LAST derivation and on-sequence membership test,
//           shared by stride_seq_counter and stride_next_calc.
// Contents: mode_e      - 2-bit mode encoding (11 behaves as wrap)
//           calc_last() - largest sequence value that fits in WIDTH bits
//           on_seq()    - true when a value is a member of BASE..LAST stepping STEP
package counter_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP   = 2'b00,
      MODE_SAT    = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_e;

   // Elaboration-time helper; width is limited to 31 so the maximum fits in 32 bits.
   function automatic int unsigned calc_last(input int unsigned width,
                                             input int unsigned base,
                                             input int unsigned step);
      int unsigned top;
      top = (32'd1 << width) - 32'd1;
      return base + ((top - base) / step) * step;
   endfunction

   // The lower-bound term short-circuits before the subtraction can underflow.
   function automatic logic on_seq(input logic [31:0] val,
                                   input logic [31:0] base,
                                   input logic [31:0] step,
                                   input logic [31:0] last);
      return (val >= base) && (val <= last) && (((val - base) % step) == 32'd0);
   endfunction

endpackage

// File: rtl/stride_next_calc.sv
// rtl/stride_next_calc.sv - combinational next-count/next-dir/wrap/tc for the stride counter
//
// Purpose : given the current count, direction register and mode, compute the
//           value the counter takes on an enabled step plus the pulse flags.
// Ports   : count_i      current registered count
//           cur_dir_i    current direction register (used in bounce mode)
//           req_dir_i    requested direction input (used in wrap/saturate)
//           mode_i       mode select (see counter_pkg::mode_e)
//           next_count_o count after an enabled step
//           next_dir_o   direction register after an enabled step
//           wrap_o       step wraps around the sequence end
//           tc_o         step arrives at the terminal value of its direction
module stride_next_calc
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned BASE  = 1,
   parameter int unsigned STEP  = 2,
   parameter int unsigned LAST  = 255
) (
   input  logic [WIDTH-1:0] count_i,
   input  logic             cur_dir_i,
   input  logic             req_dir_i,
   input  logic [1:0]       mode_i,
   output logic [WIDTH-1:0] next_count_o,
   output logic             next_dir_o,
   output logic             wrap_o,
   output logic             tc_o
);

   // One extra bit so count+STEP can never silently overflow.
   localparam logic [WIDTH:0] BASE_X = (WIDTH+1)'(BASE);
   localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
   localparam logic [WIDTH:0] LAST_X = (WIDTH+1)'(LAST);

   mode_e          mode;
   logic           eff_dir;
   logic [WIDTH:0] cur_x;
   logic [WIDTH:0] up_x;
   logic [WIDTH:0] dn_x;
   logic [WIDTH:0] nxt_x;

   always_comb begin
      mode       = mode_e'(mode_i);
      eff_dir    = (mode == MODE_BOUNCE) ? cur_dir_i : req_dir_i;
      cur_x      = {1'b0, count_i};
      up_x       = cur_x + STEP_X;
      dn_x       = cur_x - STEP_X;
      nxt_x      = cur_x;
      next_dir_o = eff_dir;
      wrap_o     = 1'b0;

      if (cur_x == '0) begin
         // 0 is off-sequence: enter at the end matching the direction, never a wrap.
         nxt_x = eff_dir ? LAST_X : BASE_X;
      end else if (!eff_dir) begin
         if (cur_x >= LAST_X) begin
            case (mode)
               MODE_SAT:    nxt_x = LAST_X;
               MODE_BOUNCE: begin
                  nxt_x      = LAST_X - STEP_X;
                  next_dir_o = 1'b1;
               end
               default: begin
                  nxt_x  = BASE_X;
                  wrap_o = 1'b1;
               end
            endcase
         end else begin
            nxt_x = up_x;
         end
      end else begin
         if (cur_x <= BASE_X) begin
            case (mode)
               MODE_SAT:    nxt_x = BASE_X;
               MODE_BOUNCE: begin
                  nxt_x      = BASE_X + STEP_X;
                  next_dir_o = 1'b0;
               end
               default: begin
                  nxt_x  = LAST_X;
                  wrap_o = 1'b1;
               end
            endcase
         end else begin
            nxt_x = dn_x;
         end
      end

      // Terminal is judged against the direction actually moved after this step;
      // requiring a change suppresses repeat pulses while saturated.
      tc_o = (nxt_x != cur_x) && (next_dir_o ? (nxt_x == BASE_X) : (nxt_x == LAST_X));
      next_count_o = nxt_x[WIDTH-1:0];
   end

endmodule

// File: rtl/stride_seq_counter.sv
// rtl/stride_seq_counter.sv - programmable arithmetic-sequence (stride) counter
//
// Purpose : generates BASE, BASE+STEP, ... LAST with up/down direction and
//           wrap / saturate / bounce end behaviour, plus validated load.
// Ports   : i_clk       clock, rising edge
//           i_rst       synchronous active-high reset
//           i_enable    advance one step this cycle
//           i_dir       0 up, 1 down (ignored in bounce)
//           i_mode      00 wrap, 01 saturate, 10 bounce, 11 wrap
//           i_load      load request (suppresses the step)
//           i_load_val  value to load
//           o_count     registered count
//           o_dir       direction register
//           o_tc        terminal-count pulse
//           o_wrap      wrap-around pulse
//           o_load_err  rejected-load pulse
module stride_seq_counter
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned BASE  = 1,
   parameter int unsigned STEP  = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_enable,
   input  logic             i_dir,
   input  logic [1:0]       i_mode,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   output logic [WIDTH-1:0] o_count,
   output logic             o_dir,
   output logic             o_tc,
   output logic             o_wrap,
   output logic             o_load_err
);

   localparam int unsigned LAST = calc_last(WIDTH, BASE, STEP);

   logic [WIDTH-1:0] count_q, count_d;
   logic             dir_q, dir_d;
   logic             tc_q, tc_d;
   logic             wrap_q, wrap_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] step_count;
   logic             step_dir;
   logic             step_wrap;
   logic             step_tc;
   logic             load_ok;

   stride_next_calc #(
      .WIDTH (WIDTH),
      .BASE  (BASE),
      .STEP  (STEP),
      .LAST  (LAST)
   ) u_next (
      .count_i      (count_q),
      .cur_dir_i    (dir_q),
      .req_dir_i    (i_dir),
      .mode_i       (i_mode),
      .next_count_o (step_count),
      .next_dir_o   (step_dir),
      .wrap_o       (step_wrap),
      .tc_o         (step_tc)
   );

   assign load_ok = on_seq(32'(i_load_val), BASE, STEP, LAST);

   // Load beats enable; pulses default low so they last exactly one cycle.
   always_comb begin
      count_d = count_q;
      dir_d   = dir_q;
      tc_d    = 1'b0;
      wrap_d  = 1'b0;
      err_d   = 1'b0;
      if (i_load) begin
         if (load_ok) begin
            count_d = i_load_val;
         end else begin
            err_d = 1'b1;
         end
      end else if (i_enable) begin
         count_d = step_count;
         dir_d   = step_dir;
         tc_d    = step_tc;
         wrap_d  = step_wrap;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count_q <= '0;
         dir_q   <= 1'b0;
         tc_q    <= 1'b0;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         dir_q   <= dir_d;
         tc_q    <= tc_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
      end
   end

   assign o_count    = count_q;
   assign o_dir      = dir_q;
   assign o_tc       = tc_q;
   assign o_wrap     = wrap_q;
   assign o_load_err = err_q;

endmodule
